// File: rtl/mult_arbiter_if.sv
// Requester-side bus of mult_arbiter: packed per-requester operands in, tagged product out.
interface mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 24,
    parameter int B_WIDTH = 24
);
    logic [NUM_REQ-1:0]                 req_i;
    logic [NUM_REQ-1:0]                 lock_i;
    logic [NUM_REQ*A_WIDTH-1:0]         a_i;
    logic [NUM_REQ*B_WIDTH-1:0]         b_i;
    logic [NUM_REQ-1:0]                 gnt_o;
    logic signed [A_WIDTH+B_WIDTH-1:0]  p_o;
    logic [NUM_REQ-1:0]                 valid_o;
    logic [31:0]                        contention_o;

    modport slave  (input  req_i, lock_i, a_i, b_i,
                    output gnt_o, p_o, valid_o, contention_o);
    modport master (output req_i, lock_i, a_i, b_i,
                    input  gnt_o, p_o, valid_o, contention_o);
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter with burst lock sharing one pipelined signed multiplier.
// Define MULT_ARB_CONTENTION_EN to build the saturating contention counter.
module mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int A_WIDTH      = 24,
    parameter int B_WIDTH      = 24,
    parameter int MULT_LATENCY = 2,
    parameter int MAX_BURST    = 32
) (
    input logic           clk_i,
    input logic           reset_i,
    mult_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = A_WIDTH + B_WIDTH;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t                state;
    logic [IW-1:0]         ptr, owner, gnt_idx;
    logic [7:0]            burst;
    logic                  hold, gnt_any;
    logic [NUM_REQ-1:0]    gnt;
    logic signed [A_WIDTH-1:0] a_sel, a_last;
    logic signed [B_WIDTH-1:0] b_sel, b_last;
    logic [NUM_REQ-1:0]    tag_last;
    logic [MULT_LATENCY:1][NUM_REQ-1:0] vld_pipe;
    logic signed [PW-1:0]  p_q;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    // A live lock owner pre-empts the round-robin search entirely.
    always_comb begin
        hold    = (state == LOCKED) && bus.req_i[owner];
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (hold) begin
            gnt_any = 1'b1;
            gnt_idx = owner;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_any && bus.req_i[rr_idx(ptr, i)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = rr_idx(ptr, i);
                end
            end
        end
        gnt = '0;
        if (gnt_any && !reset_i) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_idx == IW'(k)) begin
                a_sel = bus.a_i[k*A_WIDTH +: A_WIDTH];
                b_sel = bus.b_i[k*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // ptr is left at owner+1 on lock entry, so a burst exit makes the owner lowest priority.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
            burst <= '0;
        end else if (hold) begin
            if (!bus.lock_i[owner] || (int'(burst) + 1 >= MAX_BURST)) begin
                state <= ARB;
                burst <= '0;
            end else begin
                burst <= burst + 1'b1;
            end
        end else if (gnt_any) begin
            ptr <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            if (bus.lock_i[gnt_idx]) begin
                state <= LOCKED;
                owner <= gnt_idx;
                burst <= 8'd1;
            end else begin
                state <= ARB;
                burst <= '0;
            end
        end else begin
            state <= ARB;
            burst <= '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) vld_pipe <= '0;
        else begin
            vld_pipe[1] <= gnt;
            for (int s = 2; s <= MULT_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    // Operand stages carry no reset so they can fold into the DSP input registers.
    generate
        if (MULT_LATENCY == 1) begin : g_lat1
            assign a_last   = a_sel;
            assign b_last   = b_sel;
            assign tag_last = gnt;
        end else begin : g_latn
            logic signed [A_WIDTH-1:0] a_pipe [1:MULT_LATENCY-1];
            logic signed [B_WIDTH-1:0] b_pipe [1:MULT_LATENCY-1];
            always_ff @(posedge clk_i) begin
                a_pipe[1] <= a_sel;
                b_pipe[1] <= b_sel;
                for (int s = 2; s < MULT_LATENCY; s++) begin
                    a_pipe[s] <= a_pipe[s-1];
                    b_pipe[s] <= b_pipe[s-1];
                end
            end
            assign a_last   = a_pipe[MULT_LATENCY-1];
            assign b_last   = b_pipe[MULT_LATENCY-1];
            assign tag_last = vld_pipe[MULT_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)        p_q <= '0;
        else if (|tag_last) p_q <= PW'(a_last) * PW'(b_last);
    end

`ifdef MULT_ARB_CONTENTION_EN
    logic [31:0] cont_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cont_q <= '0;
        else if ($countones(bus.req_i) >= 2 && cont_q != 32'hFFFF_FFFF) cont_q <= cont_q + 32'd1;
    end
    assign bus.contention_o = cont_q;
`else
    assign bus.contention_o = '0;
`endif

    assign bus.gnt_o   = gnt;
    assign bus.valid_o = vld_pipe[MULT_LATENCY];
    assign bus.p_o     = p_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter (NUM_REQ=4, 24x24, latency 2, MAX_BURST=4).
module tb_mult_arbiter;
    logic clk_i = 1'b0;
    logic reset_i;
    int   checks = 0;
    int   errors = 0;

`ifdef MULT_ARB_CONTENTION_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    mult_arbiter_if #(.NUM_REQ(4), .A_WIDTH(24), .B_WIDTH(24)) bus ();

    mult_arbiter #(.NUM_REQ(4), .A_WIDTH(24), .B_WIDTH(24),
                   .MULT_LATENCY(2), .MAX_BURST(4)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic signed [23:0] a, input logic signed [23:0] b);
        bus.a_i[k*24 +: 24] = a;
        bus.b_i[k*24 +: 24] = b;
    endtask

    logic signed [47:0] p_exp [4];
    logic [3:0]         lk_exp [6];

    initial begin
        p_exp[0] = 48'sd70368744177664;    // -2^23 * -2^23
        p_exp[1] = -48'sd700;              // 100 * -7
        p_exp[2] = -48'sd70368735789056;   // (2^23-1) * -2^23
        p_exp[3] = 48'sd1;                 // -1 * -1
        lk_exp[0] = 4'b0010; lk_exp[1] = 4'b0010; lk_exp[2] = 4'b0010;
        lk_exp[3] = 4'b0010; lk_exp[4] = 4'b0100; lk_exp[5] = 4'b0010;

        reset_i = 1'b1;
        bus.req_i = '0; bus.lock_i = '0; bus.a_i = '0; bus.b_i = '0;

        // reset state, with requests present
        @(negedge clk_i); bus.req_i = 4'b1111; #1;
        chk("rst_gnt", bus.gnt_o, 4'b0000);
        chk("rst_valid", bus.valid_o, 4'b0000);
        chk("rst_p", bus.p_o, 48'sd0);
        chk("rst_cont", bus.contention_o, 32'd0);

        // single requester, -3 * 5
        @(negedge clk_i); reset_i = 1'b0; bus.req_i = 4'b0001; set_ops(0, -24'sd3, 24'sd5); #1;
        chk("single_gnt", bus.gnt_o, 4'b0001);
        chk("single_valid_t0", bus.valid_o, 4'b0000);
        @(negedge clk_i); bus.req_i = 4'b0000; #1;
        chk("single_gnt_off", bus.gnt_o, 4'b0000);
        chk("single_valid_t1", bus.valid_o, 4'b0000);
        @(negedge clk_i); #1;
        chk("single_valid_t2", bus.valid_o, 4'b0001);
        chk("single_p_t2", bus.p_o, -48'sd15);
        @(negedge clk_i); #1;
        chk("single_valid_t3", bus.valid_o, 4'b0000);
        chk("single_p_hold", bus.p_o, -48'sd15);

        // all four requesting, rotation from a fresh reset
        @(negedge clk_i); reset_i = 1'b1; #1;
        @(negedge clk_i); reset_i = 1'b0;
        set_ops(0, -24'sd8388608, -24'sd8388608);
        set_ops(1, 24'sd100, -24'sd7);
        set_ops(2, 24'sd8388607, -24'sd8388608);
        set_ops(3, -24'sd1, -24'sd1);
        bus.req_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk_i);
            #1;
            chk($sformatf("rr_gnt%0d", i), bus.gnt_o, 4'b0001 << (i % 4));
            if (i >= 2) begin
                chk($sformatf("rr_valid%0d", i), bus.valid_o, 4'b0001 << ((i - 2) % 4));
                chk($sformatf("rr_p%0d", i), bus.p_o, p_exp[(i - 2) % 4]);
            end else begin
                chk($sformatf("rr_valid%0d", i), bus.valid_o, 4'b0000);
            end
        end

        // reset with two products in flight
        @(negedge clk_i); reset_i = 1'b1; bus.req_i = 4'b0110; #1;
        chk("flush_gnt0", bus.gnt_o, 4'b0000);
        chk("flush_valid0", bus.valid_o, 4'b0000);
        @(negedge clk_i); #1;
        chk("flush_gnt1", bus.gnt_o, 4'b0000);
        chk("flush_valid1", bus.valid_o, 4'b0000);
        @(negedge clk_i); reset_i = 1'b0; #1;
        chk("flush_first_gnt", bus.gnt_o, 4'b0010);
        chk("flush_valid2", bus.valid_o, 4'b0000);
        @(negedge clk_i); bus.req_i = 4'b0000; #1;
        chk("flush_valid3", bus.valid_o, 4'b0000);
        @(negedge clk_i); #1;
        chk("flush_valid4", bus.valid_o, 4'b0010);
        chk("flush_p4", bus.p_o, p_exp[1]);

        // lock burst of MAX_BURST=4 with requester 2 pending
        @(negedge clk_i); reset_i = 1'b1; #1;
        @(negedge clk_i); reset_i = 1'b0; bus.req_i = 4'b0110; bus.lock_i = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk_i);
            #1;
            chk($sformatf("lock_gnt%0d", i), bus.gnt_o, lk_exp[i]);
        end
        // owner drops while locked, requester 3 gets the same cycle
        @(negedge clk_i); bus.req_i = 4'b1000; bus.lock_i = 4'b0000; #1;
        chk("release_gnt", bus.gnt_o, 4'b1000);
        chk("release_valid", bus.valid_o, 4'b0100);
        chk("release_p", bus.p_o, p_exp[2]);
        @(negedge clk_i); bus.req_i = 4'b0000; #1;
        chk("idle_gnt", bus.gnt_o, 4'b0000);

        // contention counter
        @(negedge clk_i); reset_i = 1'b1; #1;
        chk("cont_rst", bus.contention_o, 32'd0);
        @(negedge clk_i); reset_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk_i);
            bus.req_i = (i < 10) ? 4'b0110 : 4'b0100;
            #1;
            if (i == 5) chk("cont_mid", bus.contention_o, CEN ? 32'd5 : 32'd0);
        end
        @(negedge clk_i); bus.req_i = 4'b0000; #1;
        chk("cont_final", bus.contention_o, CEN ? 32'd10 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter sharing one pipelined signed multiplier (one DSP slice chain) between up to NUM_REQ requesters, e.g. the FIR, CIC-compensation and Hilbert filter instances in the QPD/OPD processing chain, which each only need one multiply per clock for a small fraction of the 128 kHz sample period. Each granted operand pair flows through a fixed-latency multiply pipeline. The product is returned with a one-hot valid tag identifying the requester. An optional lock lets one requester hold the multiplier for a burst of consecutive MACs.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- A_WIDTH, 24, signed operand A width
- B_WIDTH, 24, signed operand B width
- MULT_LATENCY, 2, pipeline stages from grant to result (1..4)
- MAX_BURST, 32, maximum consecutive grants under lock (2..255)

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  reset; asynchronous, active-high
- req_i  in  NUM_REQ  request, one bit per requester
- lock_i  in  NUM_REQ  keep grant next cycle, per requester
- a_i  in  NUM_REQ*A_WIDTH  packed signed operand A; requester k at [k*A_WIDTH +: A_WIDTH]
- b_i  in  NUM_REQ*B_WIDTH  packed signed operand B, same packing
- gnt_o  out  NUM_REQ  one-hot grant; combinational, same cycle as the request
- p_o  out  A_WIDTH+B_WIDTH  signed full-precision product, broadcast to all requesters
- valid_o  out  NUM_REQ  one-hot; p_o belongs to the flagged requester
- contention_o  out  32  count of cycles with ≥2 requests pending (see Configuration)

## Operation
- State: round-robin pointer ptr (highest-priority index), owner index, burst counter, FSM {ARB, LOCKED}.
- ARB: grant the first requester with req_i set, searching ptr, ptr+1, … mod NUM_REQ. On grant k:
  - ptr ← (k+1) mod NUM_REQ.
  - If lock_i[k] is set, go to LOCKED with owner=k and burst=1.
- LOCKED: if req_i[owner] is set, grant owner regardless of others and increment burst. Exit to ARB when any of these holds:
  - req_i[owner] is low. The same cycle is then arbitrated as ARB.
  - lock_i[owner] is low during a grant.
  - burst reaches MAX_BURST. After the MAX_BURST-th grant, force ARB for at least one arbitration, and the owner is lowest priority next.
- At most one grant per cycle. No grant when req_i==0.
- Handshake: requester holds req_i, a_i and b_i stable until it sees gnt_o[k]. Operands are sampled at the clock edge ending the grant cycle. req_i may drop without a grant; this has no side effects.
- Product: p = signed(a) * signed(b), computed exactly in A_WIDTH+B_WIDTH bits with no rounding or saturation. Scaling is the requester's job.
- Pipeline: a tag (one-hot grant) travels alongside the operands through MULT_LATENCY registers. Registers are retimable into the DSP.
- lock_i is ignored for non-granted requesters.

## Timing
- Grant in cycle t → valid_o[k]=1 and p_o valid in cycle t+MULT_LATENCY, for exactly one cycle.
- Throughput: one product per cycle, back-to-back across requesters, with no bubbles.
- Reset values: gnt_o=0, valid_o=0, p_o=0, contention_o=0, ptr=0, FSM=ARB, burst=0.
- Reset mid-operation flushes the pipeline. In-flight products are discarded and no valid_o is emitted for them after deassertion.
- First cycle after reset deassert: arbitration starts with requester 0 highest priority.
- p_o is held at its last value when valid_o==0; requesters must qualify it with valid_o.
- Simultaneous request and release: the owner dropping req_i in LOCKED yields a same-cycle ARB grant to another requester. No dead cycle.

## Configuration
- MULT_ARB_CONTENTION_EN defined:
  - contention_o increments on each cycle with popcount(req_i) ≥ 2.
  - It saturates at 0xFFFFFFFF and clears on reset.
  - Used for sizing NUM_REQ per multiplier.
- Not defined: contention_o is tied to 0 and no counter logic is synthesized.

## Test plan
- Single requester: req_i=0001, a=-3, b=5 in cycle 10 → gnt_o=0001 in cycle 10. With MULT_LATENCY=2, valid_o=0001 and p_o=-15 in cycle 12.
- All four requesting continuously, no lock → grants cycle 0,1,2,3,0,… from reset. valid_o follows the same sequence delayed by MULT_LATENCY. p_o matches each pair; extreme case a=-8388608, b=-8388608 → p=70368744177664.
- Lock burst: req 1 with lock_i[1] high and MAX_BURST=4, req 2 also pending → four consecutive grants to 1, then grant to 2, then 1 again only after 2 in rotation.
- Owner drops req_i while LOCKED with req 3 pending → gnt_o=1000 in the same cycle, with no idle cycle.
- Assert reset_i with two products in flight → valid_o stays 0 through and after reset. gnt_o=0 during reset. First grant after release goes to the lowest pending index.
- With MULT_ARB_CONTENTION_EN: 10 cycles of req_i=0110 then 5 cycles of 0100 → contention_o=10. Without the macro → contention_o=0 throughout.
